// File: rtl/reg_wb_arbiter.sv
// Write-port arbiter for the single-port reg_file: pipeline writeback has fixed
// priority over the MUL/DIV unit, with a pending-write scoreboard and starvation stall.
module reg_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              WB_WRITE,
    input  logic [4:0]        WB_ADDRESS,
    input  logic [DATA_W-1:0] WB_DATA,
    input  logic              MDU_VALID,
    input  logic [4:0]        MDU_ADDRESS,
    input  logic [DATA_W-1:0] MDU_DATA,
    output logic              MDU_READY,
    input  logic              ISSUE_VALID,
    input  logic [4:0]        ISSUE_ADDRESS,
    output logic [DATA_W-1:0] REG_IN,
    output logic [4:0]        REG_INADDRESS,
    output logic              REG_WRITE,
    output logic [31:0]       BUSY,
    output logic              STALL_REQ
);

    logic              wb_act;
    logic              mdu_act;
    logic              transfer;

    logic [DATA_W-1:0] reg_in_q, reg_in_d;
    logic [4:0]        reg_addr_q, reg_addr_d;
    logic              reg_write_q, reg_write_d;
    logic [31:0]       busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall_q, stall_d;

    assign wb_act  = WB_WRITE & (WB_ADDRESS != '0);
    assign mdu_act = MDU_VALID & (MDU_ADDRESS != '0);

    // An MDU result for x0 needs no port, so it is accepted even while WB owns it.
    assign MDU_READY = MDU_VALID & ~RESET & (~wb_act | (MDU_ADDRESS == '0));
    assign transfer  = MDU_VALID & MDU_READY;

    always_comb begin
        reg_in_d    = reg_in_q;
        reg_addr_d  = reg_addr_q;
        reg_write_d = 1'b0;
        busy_d      = busy_q;
        cnt_d       = '0;

        if (wb_act) begin
            reg_write_d = 1'b1;
            reg_addr_d  = WB_ADDRESS;
            reg_in_d    = WB_DATA;
        end else if (mdu_act & MDU_READY) begin
            reg_write_d = 1'b1;
            reg_addr_d  = MDU_ADDRESS;
            reg_in_d    = MDU_DATA;
        end

        // Clear before set so a re-issue to the same rd in the transfer cycle wins.
        if (transfer) begin
            busy_d[MDU_ADDRESS] = 1'b0;
        end
        if (ISSUE_VALID & (ISSUE_ADDRESS != '0)) begin
            busy_d[ISSUE_ADDRESS] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (MDU_VALID & ~MDU_READY) begin
            cnt_d = (cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        end

        stall_d = (cnt_d >= CNT_W'(STARVE_LIMIT)) & ~transfer;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            reg_in_q    <= '0;
            reg_addr_q  <= '0;
            reg_write_q <= 1'b0;
            busy_q      <= '0;
            cnt_q       <= '0;
            stall_q     <= 1'b0;
        end else begin
            reg_in_q    <= reg_in_d;
            reg_addr_q  <= reg_addr_d;
            reg_write_q <= reg_write_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign REG_IN        = reg_in_q;
    assign REG_INADDRESS = reg_addr_q;
    assign REG_WRITE     = reg_write_q;
    assign BUSY          = busy_q;
    assign STALL_REQ     = stall_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: expected port writes are queued as stimulus
// is driven and compared one cycle later against the registered outputs.
module tb_reg_wb_arbiter;

    localparam int DATA_W = 32;

    logic              CLOCK = 1'b0;
    logic              RESET;
    logic              WB_WRITE;
    logic [4:0]        WB_ADDRESS;
    logic [DATA_W-1:0] WB_DATA;
    logic              MDU_VALID;
    logic [4:0]        MDU_ADDRESS;
    logic [DATA_W-1:0] MDU_DATA;
    logic              MDU_READY;
    logic              ISSUE_VALID;
    logic [4:0]        ISSUE_ADDRESS;
    logic [DATA_W-1:0] REG_IN;
    logic [4:0]        REG_INADDRESS;
    logic              REG_WRITE;
    logic [31:0]       BUSY;
    logic              STALL_REQ;

    reg_wb_arbiter #(
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4),
        .CNT_W        (3)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .WB_WRITE      (WB_WRITE),
        .WB_ADDRESS    (WB_ADDRESS),
        .WB_DATA       (WB_DATA),
        .MDU_VALID     (MDU_VALID),
        .MDU_ADDRESS   (MDU_ADDRESS),
        .MDU_DATA      (MDU_DATA),
        .MDU_READY     (MDU_READY),
        .ISSUE_VALID   (ISSUE_VALID),
        .ISSUE_ADDRESS (ISSUE_ADDRESS),
        .REG_IN        (REG_IN),
        .REG_INADDRESS (REG_INADDRESS),
        .REG_WRITE     (REG_WRITE),
        .BUSY          (BUSY),
        .STALL_REQ     (STALL_REQ)
    );

    always #5 CLOCK = ~CLOCK;

    // Stand-in for reg_file so committed values can be read back by register number.
    logic [DATA_W-1:0] rf [32];
    always @(posedge CLOCK) begin
        if (REG_WRITE) rf[REG_INADDRESS] <= REG_IN;
    end

    typedef struct {
        logic              wr;
        logic [4:0]        a;
        logic [DATA_W-1:0] d;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [4:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        e.wr = wr; e.a = a; e.d = d;
        expq.push_back(e);
    endtask

    // Advance one cycle and compare the registered port against the queued expectation.
    task automatic step();
        exp_t e;
        @(posedge CLOCK);
        @(negedge CLOCK);
        if (expq.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = expq.pop_front();
            chk("reg_write", {31'd0, REG_WRITE}, {31'd0, e.wr});
            chk("reg_addr", {27'd0, REG_INADDRESS}, {27'd0, e.a});
            chk("reg_in", REG_IN, e.d);
        end
    endtask

    task automatic idle_inputs();
        WB_WRITE = 1'b0; WB_ADDRESS = '0; WB_DATA = '0;
        MDU_VALID = 1'b0; MDU_ADDRESS = '0; MDU_DATA = '0;
        ISSUE_VALID = 1'b0; ISSUE_ADDRESS = '0;
    endtask

    task automatic ready_is(input string tag, input logic exp);
        #1;
        chk(tag, {31'd0, MDU_READY}, {31'd0, exp});
    endtask

    initial begin
        RESET = 1'b1;
        idle_inputs();

        // Reset with random traffic; MDU_VALID held high so READY low is meaningful.
        for (int i = 0; i < 2; i++) begin
            WB_WRITE = 1'b0; WB_ADDRESS = 5'($urandom); WB_DATA = $urandom;
            MDU_VALID = 1'b1; MDU_ADDRESS = 5'($urandom_range(1, 31)); MDU_DATA = $urandom;
            ISSUE_VALID = 1'b1; ISSUE_ADDRESS = 5'($urandom_range(1, 31));
            ready_is("ready_in_reset", 1'b0);
            push(1'b0, 5'd0, '0);
            step();
        end
        chk("busy_reset", BUSY, 32'd0);
        chk("stall_reset", {31'd0, STALL_REQ}, 32'd0);
        RESET = 1'b0;
        idle_inputs();

        // WB only: x2 = 95
        WB_WRITE = 1'b1; WB_ADDRESS = 5'd2; WB_DATA = 32'd95;
        ready_is("ready_wb_only", 1'b0);
        push(1'b1, 5'd2, 32'd95);
        step();
        idle_inputs();
        push(1'b0, 5'd2, 32'd95);
        step();
        chk("rf_x2", rf[2], 32'd95);

        // Conflict: WB x1=28 vs MDU x4=6, WB then absent
        ISSUE_VALID = 1'b1; ISSUE_ADDRESS = 5'd4;
        push(1'b0, 5'd2, 32'd95);
        step();
        chk("busy_x4_set", BUSY, 32'h0000_0010);
        idle_inputs();
        WB_WRITE = 1'b1; WB_ADDRESS = 5'd1; WB_DATA = 32'd28;
        MDU_VALID = 1'b1; MDU_ADDRESS = 5'd4; MDU_DATA = 32'd6;
        ready_is("ready_conflict", 1'b0);
        push(1'b1, 5'd1, 32'd28);
        step();
        chk("busy_x4_held", BUSY, 32'h0000_0010);
        WB_WRITE = 1'b0;
        ready_is("ready_after_wb", 1'b1);
        push(1'b1, 5'd4, 32'd6);
        step();
        chk("busy_x4_clear", BUSY, 32'd0);
        chk("stall_after_conflict", {31'd0, STALL_REQ}, 32'd0);
        idle_inputs();
        push(1'b0, 5'd4, 32'd6);
        step();
        chk("rf_x1", rf[1], 32'd28);
        chk("rf_x4", rf[4], 32'd6);

        // Scoreboard: re-issue x5 in the cycle its result transfers
        ISSUE_VALID = 1'b1; ISSUE_ADDRESS = 5'd5;
        push(1'b0, 5'd4, 32'd6);
        step();
        chk("busy_x5_set", BUSY, 32'h0000_0020);
        MDU_VALID = 1'b1; MDU_ADDRESS = 5'd5; MDU_DATA = 32'd77;
        ready_is("ready_x5", 1'b1);
        push(1'b1, 5'd5, 32'd77);
        step();
        chk("busy_x5_set_wins", BUSY, 32'h0000_0020);
        idle_inputs();
        ISSUE_VALID = 1'b1; ISSUE_ADDRESS = 5'd0;
        push(1'b0, 5'd5, 32'd77);
        step();
        chk("busy_issue_x0", BUSY, 32'h0000_0020);
        idle_inputs();
        MDU_VALID = 1'b1; MDU_ADDRESS = 5'd5; MDU_DATA = 32'd78;
        push(1'b1, 5'd5, 32'd78);
        step();
        chk("busy_x5_clear", BUSY, 32'd0);

        // Starvation: MDU x7=15 against continuous WB, past counter saturation
        idle_inputs();
        ISSUE_VALID = 1'b1; ISSUE_ADDRESS = 5'd7;
        push(1'b0, 5'd5, 32'd78);
        step();
        idle_inputs();
        MDU_VALID = 1'b1; MDU_ADDRESS = 5'd7; MDU_DATA = 32'd15;
        for (int i = 0; i < 9; i++) begin
            WB_WRITE = 1'b1; WB_ADDRESS = 5'(10 + i); WB_DATA = 32'(100 + i);
            ready_is("ready_starved", 1'b0);
            push(1'b1, 5'(10 + i), 32'(100 + i));
            step();
            chk($sformatf("stall_wait%0d", i), {31'd0, STALL_REQ}, (i >= 3) ? 32'd1 : 32'd0);
        end
        chk("busy_x7_pending", BUSY, 32'h0000_0080);
        WB_WRITE = 1'b0;
        ready_is("ready_bubble", 1'b1);
        push(1'b1, 5'd7, 32'd15);
        step();
        chk("stall_released", {31'd0, STALL_REQ}, 32'd0);
        chk("busy_x7_clear", BUSY, 32'd0);
        idle_inputs();
        push(1'b0, 5'd7, 32'd15);
        step();
        chk("rf_x7", rf[7], 32'd15);

        // x0 targets
        WB_WRITE = 1'b1; WB_ADDRESS = 5'd0; WB_DATA = 32'd50;
        push(1'b0, 5'd7, 32'd15);
        step();
        WB_WRITE = 1'b1; WB_ADDRESS = 5'd3; WB_DATA = 32'd44;
        MDU_VALID = 1'b1; MDU_ADDRESS = 5'd0; MDU_DATA = 32'd33;
        ready_is("ready_mdu_x0_vs_wb", 1'b1);
        push(1'b1, 5'd3, 32'd44);
        step();
        WB_WRITE = 1'b0;
        ready_is("ready_mdu_x0_alone", 1'b1);
        push(1'b0, 5'd3, 32'd44);
        step();
        chk("stall_x0", {31'd0, STALL_REQ}, 32'd0);

        // Reset mid-transfer with a stall asserted
        idle_inputs();
        ISSUE_VALID = 1'b1; ISSUE_ADDRESS = 5'd9;
        push(1'b0, 5'd3, 32'd44);
        step();
        idle_inputs();
        MDU_VALID = 1'b1; MDU_ADDRESS = 5'd9; MDU_DATA = 32'd99;
        for (int i = 0; i < 4; i++) begin
            WB_WRITE = 1'b1; WB_ADDRESS = 5'd20; WB_DATA = 32'(200 + i);
            push(1'b1, 5'd20, 32'(200 + i));
            step();
        end
        chk("stall_before_reset", {31'd0, STALL_REQ}, 32'd1);
        chk("busy_before_reset", BUSY, 32'h0000_0200);
        RESET = 1'b1;
        ready_is("ready_mid_reset", 1'b0);
        push(1'b0, 5'd0, '0);
        step();
        chk("busy_mid_reset", BUSY, 32'd0);
        chk("stall_mid_reset", {31'd0, STALL_REQ}, 32'd0);
        RESET = 1'b0;
        idle_inputs();
        push(1'b0, 5'd0, '0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
